// File: rtl/usb4_frac_clk_gen.sv
// rtl/usb4_frac_clk_gen.sv - multi-channel fractional clock-enable generator
module usb4_frac_clk_gen #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int FRAC_W = 8,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              local_clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_i,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_int,
    input  logic [FRAC_W-1:0] cfg_frac,
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] clk_o,
    output logic [NUM_CH-1:0] pending_o,
    output logic              cfg_err
);

    localparam logic [CNT_W:0]   ONE_P   = 1;
    localparam logic [CNT_W-1:0] ONE_INT = 1;

    logic [CNT_W-1:0]  act_int   [NUM_CH];
    logic [FRAC_W-1:0] act_frac  [NUM_CH];
    logic [CNT_W-1:0]  pend_int  [NUM_CH];
    logic [FRAC_W-1:0] pend_frac [NUM_CH];
    logic [CNT_W-1:0]  cnt       [NUM_CH];
    logic [FRAC_W-1:0] acc       [NUM_CH];
    logic [CNT_W:0]    per       [NUM_CH];
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] tick_q;
    logic [NUM_CH-1:0] clk_q;
    logic              err_q;

    logic              cfg_bad;
    logic [NUM_CH-1:0] wr_hit;
    logic [NUM_CH-1:0] terminal;
    logic [NUM_CH-1:0] apply;
    logic [CNT_W-1:0]  eff_int   [NUM_CH];
    logic [FRAC_W-1:0] eff_frac  [NUM_CH];
    logic [FRAC_W:0]   acc_sum   [NUM_CH];
    logic [CNT_W:0]    next_per  [NUM_CH];

    // Out-of-range channels are rejected before any array is indexed.
    always_comb begin
        cfg_bad = cfg_we && ((cfg_int == '0) || (int'(cfg_ch) >= NUM_CH));
        for (int i = 0; i < NUM_CH; i++) begin
            wr_hit[i]   = cfg_we && !cfg_bad && (int'(cfg_ch) == i);
            terminal[i] = ch_en[i] && ({1'b0, cnt[i]} == (per[i] - ONE_P));
            apply[i]    = pend[i] && (terminal[i] || !ch_en[i] || sync_i);
            eff_int[i]  = apply[i] ? pend_int[i]  : act_int[i];
            eff_frac[i] = apply[i] ? pend_frac[i] : act_frac[i];
            acc_sum[i]  = {1'b0, acc[i]} + {1'b0, eff_frac[i]};
            // Carry out of the phase accumulator stretches the next period by one cycle.
            next_per[i] = {1'b0, eff_int[i]} + {{CNT_W{1'b0}}, acc_sum[i][FRAC_W]};
        end
    end

    always_ff @(posedge local_clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                act_int[i]   <= ONE_INT;
                act_frac[i]  <= '0;
                pend_int[i]  <= ONE_INT;
                pend_frac[i] <= '0;
                cnt[i]       <= '0;
                acc[i]       <= '0;
                per[i]       <= ONE_P;
            end
            pend   <= '0;
            tick_q <= '0;
            clk_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= cfg_bad;
            for (int i = 0; i < NUM_CH; i++) begin
                if (apply[i]) begin
                    act_int[i]  <= pend_int[i];
                    act_frac[i] <= pend_frac[i];
                    pend[i]     <= 1'b0;
                end
                // A write on the apply edge lands after the apply and keeps the flag set.
                if (wr_hit[i]) begin
                    pend_int[i]  <= cfg_int;
                    pend_frac[i] <= cfg_frac;
                    pend[i]      <= 1'b1;
                end

                if (!ch_en[i] || sync_i) begin
                    cnt[i]    <= '0;
                    acc[i]    <= '0;
                    per[i]    <= {1'b0, eff_int[i]};
                    tick_q[i] <= 1'b0;
                    clk_q[i]  <= 1'b0;
                end else if (terminal[i]) begin
                    cnt[i]    <= '0;
                    acc[i]    <= acc_sum[i][FRAC_W-1:0];
                    per[i]    <= next_per[i];
                    tick_q[i] <= 1'b1;
                    clk_q[i]  <= ~clk_q[i];
                end else begin
                    cnt[i]    <= cnt[i] + ONE_INT;
                    tick_q[i] <= 1'b0;
                end
            end
        end
    end

    assign tick_o    = tick_q;
    assign clk_o     = clk_q;
    assign pending_o = pend;
    assign cfg_err   = err_q;

endmodule
